des_cbc_ctrl: RTL and testbench

DES_CBC_CTRL -- requirements
Module: des_cbc_ctrl

---
 rtl/des_pkg.sv | 14 +
 rtl/des_wdog.sv | 39 +++
 rtl/des_cbc_ctrl.sv | 142 ++++++++++++++
 tb/tb_des_cbc_ctrl.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared widths, default core timeout and FSM encoding for the DES CBC controller.
package des_pkg;

    localparam int DES_BLK_W        = 64;
    localparam int CORE_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UPDATE = 2'd3
    } des_state_e;

endpackage

// File: rtl/des_wdog.sv
// des_wdog: clearable up-counter whose expiry flag marks the cycle in which
// TIMEOUT cycles of waiting are used up.
module des_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int            CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count parks on its last value, so a stalled enable can never wrap it.
    assign expired_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/des_cbc_ctrl.sv
// des_cbc_ctrl: runs one block through an external DES core in ECB or CBC mode.
// Define DES_CBC_DECRYPT_EN to enable decryption; otherwise the controller is encrypt-only.
module des_cbc_ctrl
    import des_pkg::*;
#(
    parameter int CORE_TIMEOUT = CORE_TIMEOUT_DEF
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 start,
    input  logic                 cbc,
    input  logic                 encrypt,
    input  logic [DES_BLK_W-1:0] blk_in,
    input  logic [DES_BLK_W-1:0] iv_q,
    output logic                 iv_deswr,
    output logic [DES_BLK_W-1:0] iv_data_all,
    output logic                 core_start,
    output logic                 core_encrypt,
    output logic [DES_BLK_W-1:0] core_din,
    input  logic                 core_done,
    input  logic [DES_BLK_W-1:0] core_dout,
    output logic [DES_BLK_W-1:0] blk_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 err
);

    des_state_e           state_q, state_d;
    logic [DES_BLK_W-1:0] blk_q, blk_d;
    logic                 cbc_q, cbc_d;
    logic                 enc_q, enc_d;
    logic [DES_BLK_W-1:0] din_q, din_d;
    logic [DES_BLK_W-1:0] blk_out_q, blk_out_d;
    logic [DES_BLK_W-1:0] iv_data_q, iv_data_d;

    logic                 enc_in;
    logic [DES_BLK_W-1:0] result;
    logic                 wdog_clr;
    logic                 wdog_en;
    logic                 wdog_expired;

`ifdef DES_CBC_DECRYPT_EN
    assign enc_in       = encrypt;
    assign core_encrypt = enc_q;
    assign result       = (cbc_q && !enc_q) ? (core_dout ^ iv_q) : core_dout;
`else
    assign enc_in       = encrypt | 1'b1;
    assign core_encrypt = 1'b1;
    assign result       = core_dout;
`endif

    des_wdog #(
        .TIMEOUT (CORE_TIMEOUT)
    ) u_wdog (
        .clk_i     (hclk),
        .rst_n_i   (hresetn),
        .clr_i     (wdog_clr),
        .en_i      (wdog_en),
        .expired_o (wdog_expired)
    );

    always_comb begin
        state_d    = state_q;
        blk_d      = blk_q;
        cbc_d      = cbc_q;
        enc_d      = enc_q;
        din_d      = din_q;
        blk_out_d  = blk_out_q;
        iv_data_d  = iv_data_q;
        core_start = 1'b0;
        out_valid  = 1'b0;
        iv_deswr   = 1'b0;
        err        = 1'b0;
        wdog_clr   = 1'b0;
        wdog_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    blk_d   = blk_in;
                    cbc_d   = cbc;
                    enc_d   = enc_in;
                    // Pre-whitening is folded in at accept so core_din is stable for the whole launch.
                    din_d   = (cbc && enc_in) ? (blk_in ^ iv_q) : blk_in;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                core_start = 1'b1;
                wdog_clr   = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                wdog_en = 1'b1;
                if (core_done) begin
                    blk_out_d = result;
                    if (cbc_q) begin
                        iv_data_d = enc_q ? result : blk_q;
                    end
                    state_d = ST_UPDATE;
                end else if (wdog_expired) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                out_valid = 1'b1;
                iv_deswr  = cbc_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q   <= ST_IDLE;
            blk_q     <= '0;
            cbc_q     <= 1'b0;
            enc_q     <= 1'b0;
            din_q     <= '0;
            blk_out_q <= '0;
            iv_data_q <= '0;
        end else begin
            state_q   <= state_d;
            blk_q     <= blk_d;
            cbc_q     <= cbc_d;
            enc_q     <= enc_d;
            din_q     <= din_d;
            blk_out_q <= blk_out_d;
            iv_data_q <= iv_data_d;
        end
    end

    assign core_din    = din_q;
    assign blk_out     = blk_out_q;
    assign iv_data_all = iv_data_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// tb_des_cbc_ctrl: randomized and directed checks of des_cbc_ctrl against a CBC/ECB reference model.
// Two instances: dutA (default timeout, modelled core) and dutB (timeout 8, core driven by the tasks).
module tb_des_cbc_ctrl;

    localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;
    // core_done lands in the 16th cycle counting the core_start cycle as the first
    localparam int          CORE_LAT = 15;
    localparam int          TO_B     = 8;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic hresetn;

    logic        startA, cbcA, encA;
    logic [63:0] blkA, ivA;
    logic        iv_deswrA, core_startA, core_encA, core_doneA, out_validA, busyA, errA;
    logic [63:0] iv_dataA, core_dinA, core_doutA, blk_outA;

    logic        startB, cbcB, encB;
    logic [63:0] blkB, ivB;
    logic        iv_deswrB, core_startB, core_encB, core_doneB, out_validB, busyB, errB;
    logic [63:0] iv_dataB, core_dinB, core_doutB, blk_outB;

    int checks = 0;
    int errors = 0;

    des_cbc_ctrl dutA (
        .hclk(hclk), .hresetn(hresetn), .start(startA), .cbc(cbcA), .encrypt(encA),
        .blk_in(blkA), .iv_q(ivA), .iv_deswr(iv_deswrA), .iv_data_all(iv_dataA),
        .core_start(core_startA), .core_encrypt(core_encA), .core_din(core_dinA),
        .core_done(core_doneA), .core_dout(core_doutA), .blk_out(blk_outA),
        .out_valid(out_validA), .busy(busyA), .err(errA)
    );

    des_cbc_ctrl #(.CORE_TIMEOUT(TO_B)) dutB (
        .hclk(hclk), .hresetn(hresetn), .start(startB), .cbc(cbcB), .encrypt(encB),
        .blk_in(blkB), .iv_q(ivB), .iv_deswr(iv_deswrB), .iv_data_all(iv_dataB),
        .core_start(core_startB), .core_encrypt(core_encB), .core_din(core_dinB),
        .core_done(core_doneB), .core_dout(core_doutB), .blk_out(blk_outB),
        .out_valid(out_validB), .busy(busyB), .err(errB)
    );

    // IV register for dutA: reloads on iv_deswr, can be preset by the tests, never reset.
    logic        ivForceEn  = 1'b0;
    logic [63:0] ivForceVal = '0;
    always @(posedge hclk) begin
        if (ivForceEn) ivA = ivForceVal;
        else if (iv_deswrA === 1'b1) ivA = iv_dataA;
    end

    // Core model for dutA: inverts its input after a fixed latency; forgets pending work on reset.
    int          doneCntA = 0;
    logic [63:0] heldDinA = '0;
    always @(posedge hclk) begin
        #1;
        core_doneA = 1'b0;
        if (hresetn !== 1'b1) begin
            doneCntA = 0;
        end else begin
            if (doneCntA > 0) begin
                doneCntA--;
                if (doneCntA == 0) begin
                    core_doneA = 1'b1;
                    core_doutA = heldDinA ^ ONES;
                end
            end
            if (core_startA === 1'b1) begin
                doneCntA = CORE_LAT;
                heldDinA = core_dinA;
            end
        end
    end

    function automatic logic effEnc(input logic e);
`ifdef DES_CBC_DECRYPT_EN
        return e;
`else
        return e | 1'b1;
`endif
    endfunction

    // CBC from first principles: encrypt whitens the plaintext with the IV and chains the
    // ciphertext; decrypt unwhitens the core output and chains the incoming ciphertext.
    task automatic refModel(input logic [63:0] blk, input logic [63:0] iv, input logic cbcIn,
                            input logic encIn, output logic [63:0] din, output logic [63:0] res,
                            output logic [63:0] ivNext, output logic ivWr);
        logic        e;
        logic [63:0] coreOut;
        e       = effEnc(encIn);
        din     = (cbcIn && e) ? (blk ^ iv) : blk;
        coreOut = ~din;
        res     = (cbcIn && !e) ? (coreOut ^ iv) : coreOut;
        ivWr    = cbcIn;
        ivNext  = cbcIn ? (e ? res : blk) : iv;
    endtask

    task automatic setIvA(input logic [63:0] v);
        @(negedge hclk);
        ivForceVal = v;
        ivForceEn  = 1'b1;
        @(negedge hclk);
        ivForceEn  = 1'b0;
    endtask

    task automatic runBlockA(input string tag, input logic [63:0] blk, input logic cbcIn,
                             input logic encIn, input bit pokeStart, output logic [63:0] gotDin,
                             output logic [63:0] gotOut, output logic [63:0] gotIv);
        logic [63:0] expDin, expRes, expIv;
        logic        expWr;
        int          nOut, outCyc, nWr, wrCyc, nErr, nExtra;
        refModel(blk, ivA, cbcIn, encIn, expDin, expRes, expIv, expWr);
        gotOut = '0; gotIv = '0;
        nOut = 0; outCyc = -1; nWr = 0; wrCyc = -1; nErr = 0; nExtra = 0;
        @(negedge hclk);
        startA = 1'b1; blkA = blk; cbcA = cbcIn; encA = encIn;
        @(negedge hclk);
        startA = 1'b0; blkA = {$urandom, $urandom}; cbcA = 1'($urandom); encA = 1'($urandom);
        gotDin = core_dinA;
        checks++;
        if (core_startA !== 1'b1 || core_dinA !== expDin) begin
            errors++;
            $display("[TB] FAIL %s launch: core_start=%b core_din=%h, expected 1 and %h",
                     tag, core_startA, core_dinA, expDin);
        end
        checks++;
        if (core_encA !== effEnc(encIn)) begin
            errors++;
            $display("[TB] FAIL %s direction: core_encrypt=%b, expected %b", tag, core_encA, effEnc(encIn));
        end
        for (int cyc = 2; cyc <= 22; cyc++) begin
            @(negedge hclk);
            if (core_startA === 1'b1) nExtra++;
            if (errA === 1'b1) nErr++;
            if (iv_deswrA === 1'b1) begin nWr++; wrCyc = cyc; gotIv = iv_dataA; end
            if (out_validA === 1'b1) begin nOut++; outCyc = cyc; gotOut = blk_outA; end
            startA = (pokeStart && cyc == 5) ? 1'b1 : 1'b0;
        end
        checks++;
        if (nOut != 1 || outCyc != 17 || gotOut !== expRes) begin
            errors++;
            $display("[TB] FAIL %s result: %0d strobes, last at cycle %0d with %h, expected 1 at cycle 17 with %h",
                     tag, nOut, outCyc, gotOut, expRes);
        end
        checks++;
        if (nWr != (expWr ? 1 : 0) || (expWr && (wrCyc != 17 || gotIv !== expIv))) begin
            errors++;
            $display("[TB] FAIL %s iv_reload: %0d strobes at cycle %0d with %h, expected %0d at cycle 17 with %h",
                     tag, nWr, wrCyc, gotIv, expWr ? 1 : 0, expIv);
        end
        checks++;
        if (nErr != 0 || nExtra != 0 || busyA !== 1'b0 || blk_outA !== expRes) begin
            errors++;
            $display("[TB] FAIL %s quiet: err=%0d extra_core_start=%0d busy=%b blk_out=%h, expected 0 0 0 %h",
                     tag, nErr, nExtra, busyA, blk_outA, expRes);
        end
        checks++;
        if (ivA !== expIv) begin
            errors++;
            $display("[TB] FAIL %s iv_register: got %h, expected %h", tag, ivA, expIv);
        end
    endtask

    task automatic test_reset;
        hresetn = 1'b0;
        repeat (3) @(negedge hclk);
        checks++;
        if ({busyA, core_startA, iv_deswrA, out_validA, errA, busyB, errB} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes: busy/core_start/iv_deswr/out_valid/err/busyB/errB=%b, expected all 0",
                     {busyA, core_startA, iv_deswrA, out_validA, errA, busyB, errB});
        end
        checks++;
        if (core_dinA !== 64'h0 || iv_dataA !== 64'h0 || blk_outA !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: core_din=%h iv_data_all=%h blk_out=%h, expected all zero",
                     core_dinA, iv_dataA, blk_outA);
        end
        hresetn = 1'b1;
    endtask

    task automatic test_cbc_encrypt;
        logic [63:0] d, o, v;
        setIvA(64'h0123456789ABCDEF);
        runBlockA("cbc_enc", 64'h0, 1'b1, 1'b1, 1'b0, d, o, v);
        checks++;
        if (d !== 64'h0123456789ABCDEF || o !== 64'hFEDCBA9876543210 || v !== 64'hFEDCBA9876543210) begin
            errors++;
            $display("[TB] FAIL cbc_enc_vector: din=%h out=%h iv=%h, expected 0123456789abcdef fedcba9876543210 fedcba9876543210",
                     d, o, v);
        end
    endtask

`ifdef DES_CBC_DECRYPT_EN
    task automatic test_cbc_decrypt;
        logic [63:0] d, o, v;
        setIvA(64'h1111111111111111);
        runBlockA("cbc_dec", 64'hFFFFFFFF00000000, 1'b1, 1'b0, 1'b0, d, o, v);
        checks++;
        if (d !== 64'hFFFFFFFF00000000 || o !== 64'h11111111EEEEEEEE || v !== 64'hFFFFFFFF00000000) begin
            errors++;
            $display("[TB] FAIL cbc_dec_vector: din=%h out=%h iv=%h, expected ffffffff00000000 11111111eeeeeeee ffffffff00000000",
                     d, o, v);
        end
    endtask
`endif

    task automatic test_ecb;
        logic [63:0] d, o, v;
        runBlockA("ecb", 64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b1, 1'b0, d, o, v);
        checks++;
        if (o !== 64'h5A5A5A5A5A5A5A5A) begin
            errors++;
            $display("[TB] FAIL ecb_vector: out=%h, expected 5a5a5a5a5a5a5a5a", o);
        end
    endtask

    task automatic test_random;
        logic [63:0] d, o, v;
        setIvA({$urandom, $urandom});
        for (int i = 0; i < 12; i++) begin
            runBlockA($sformatf("random%0d", i), {$urandom, $urandom}, 1'($urandom), 1'($urandom),
                      1'b0, d, o, v);
        end
    endtask

    task automatic test_start_while_busy;
        logic [63:0] d, o, v;
        runBlockA("busy_start", {$urandom, $urandom}, 1'b1, 1'b1, 1'b1, d, o, v);
    endtask

    task automatic test_back_to_back;
        logic [63:0] blk1, blk2, din1, din2, res1, res2, iv1, iv2;
        logic        wr1, wr2;
        int          nStart, startCyc2, nOut, outCyc1, outCyc2;
        logic [63:0] gotDin2, gotOut1, gotOut2;
        blk1 = {$urandom, $urandom};
        blk2 = {$urandom, $urandom};
        refModel(blk1, ivA, 1'b1, 1'b1, din1, res1, iv1, wr1);
        refModel(blk2, iv1, 1'b1, 1'b1, din2, res2, iv2, wr2);
        nStart = 0; startCyc2 = -1; nOut = 0; outCyc1 = -1; outCyc2 = -1;
        gotDin2 = '0; gotOut1 = '0; gotOut2 = '0;
        @(negedge hclk);
        startA = 1'b1; blkA = blk1; cbcA = 1'b1; encA = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge hclk);
            if (core_startA === 1'b1) begin
                nStart++;
                if (nStart == 2) begin startCyc2 = cyc; gotDin2 = core_dinA; end
            end
            if (out_validA === 1'b1) begin
                nOut++;
                if (nOut == 1) begin outCyc1 = cyc; gotOut1 = blk_outA; end
                else begin outCyc2 = cyc; gotOut2 = blk_outA; end
            end
            if (cyc == 17) blkA = blk2;
            if (cyc == 19) startA = 1'b0;
        end
        checks++;
        if (nStart != 2 || startCyc2 != 19 || gotDin2 !== din2) begin
            errors++;
            $display("[TB] FAIL b2b_relaunch: %0d launches, second at cycle %0d din=%h, expected 2 at cycle 19 din=%h",
                     nStart, startCyc2, gotDin2, din2);
        end
        checks++;
        if (nOut != 2 || outCyc1 != 17 || outCyc2 != 35 || gotOut1 !== res1 || gotOut2 !== res2) begin
            errors++;
            $display("[TB] FAIL b2b_results: %0d strobes at %0d/%0d with %h/%h, expected 2 at 17/35 with %h/%h",
                     nOut, outCyc1, outCyc2, gotOut1, gotOut2, res1, res2);
        end
        checks++;
        if (ivA !== iv2) begin
            errors++;
            $display("[TB] FAIL b2b_iv: got %h, expected %h", ivA, iv2);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] ivBefore, d, o, v;
        int          nWr, nOut, nStart;
        ivBefore = ivA;
        nWr = 0; nOut = 0; nStart = 0;
        @(negedge hclk);
        startA = 1'b1; blkA = {$urandom, $urandom}; cbcA = 1'b1; encA = 1'b1;
        @(negedge hclk);
        startA = 1'b0;
        repeat (5) @(negedge hclk);
        hresetn = 1'b0;
        @(negedge hclk);
        checks++;
        if (busyA !== 1'b0 || iv_deswrA !== 1'b0 || out_validA !== 1'b0 || core_dinA !== 64'h0 ||
            blk_outA !== 64'h0 || iv_dataA !== 64'h0) begin
            errors++;
            $display("[TB] FAIL midreset_state: busy=%b iv_deswr=%b out_valid=%b din=%h out=%h ivd=%h, expected all zero",
                     busyA, iv_deswrA, out_validA, core_dinA, blk_outA, iv_dataA);
        end
        hresetn = 1'b1;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge hclk);
            if (iv_deswrA === 1'b1) nWr++;
            if (out_validA === 1'b1) nOut++;
            if (core_startA === 1'b1) nStart++;
        end
        checks++;
        if (nWr != 0 || nOut != 0 || nStart != 0 || ivA !== ivBefore) begin
            errors++;
            $display("[TB] FAIL midreset_abandon: iv_deswr=%0d out_valid=%0d core_start=%0d iv=%h, expected 0 0 0 iv=%h",
                     nWr, nOut, nStart, ivA, ivBefore);
        end
        runBlockA("after_reset", {$urandom, $urandom}, 1'b1, 1'b1, 1'b0, d, o, v);
    endtask

    // dutB: core_done withheld until the timeout fires.
    task automatic test_timeout;
        int nErr, errCyc, nOut, nWr;
        nErr = 0; errCyc = -1; nOut = 0; nWr = 0;
        @(negedge hclk);
        startB = 1'b1; blkB = {$urandom, $urandom}; cbcB = 1'b1; encB = 1'b1; core_doneB = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge hclk);
            startB = 1'b0;
            #1;
            if (errB === 1'b1) begin nErr++; errCyc = cyc; end
            if (out_validB === 1'b1) nOut++;
            if (iv_deswrB === 1'b1) nWr++;
            if (cyc == TO_B + 2) begin
                checks++;
                if (busyB !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL timeout_idle: busy=%b the cycle after err, expected 0", busyB);
                end
            end
        end
        checks++;
        if (nErr != 1 || errCyc != TO_B + 1) begin
            errors++;
            $display("[TB] FAIL timeout_err: %0d pulses, last at cycle %0d, expected 1 at cycle %0d",
                     nErr, errCyc, TO_B + 1);
        end
        checks++;
        if (nOut != 0 || nWr != 0) begin
            errors++;
            $display("[TB] FAIL timeout_silent: out_valid=%0d iv_deswr=%0d, expected 0 0", nOut, nWr);
        end
    endtask

    // dutB: core_done arrives in the very cycle the timeout expires and must win.
    task automatic test_timeout_priority;
        logic [63:0] blk, din, res, ivn;
        logic        wr;
        int          nErr, nOut, outCyc;
        logic [63:0] gotOut, gotIv;
        blk = {$urandom, $urandom};
        refModel(blk, ivB, 1'b1, 1'b1, din, res, ivn, wr);
        nErr = 0; nOut = 0; outCyc = -1; gotOut = '0; gotIv = '0;
        @(negedge hclk);
        startB = 1'b1; blkB = blk; cbcB = 1'b1; encB = 1'b1; core_doneB = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge hclk);
            startB = 1'b0;
            core_doneB = (cyc == TO_B + 1) ? 1'b1 : 1'b0;
            core_doutB = core_dinB ^ ONES;
            #1;
            if (errB === 1'b1) nErr++;
            if (out_validB === 1'b1) begin
                nOut++; outCyc = cyc; gotOut = blk_outB; gotIv = iv_dataB;
            end
        end
        checks++;
        if (nErr != 0 || nOut != 1 || outCyc != TO_B + 2) begin
            errors++;
            $display("[TB] FAIL done_priority: err=%0d out_valid=%0d at cycle %0d, expected 0 1 at cycle %0d",
                     nErr, nOut, outCyc, TO_B + 2);
        end
        checks++;
        if (gotOut !== res || gotIv !== ivn) begin
            errors++;
            $display("[TB] FAIL done_priority_data: out=%h iv=%h, expected %h %h", gotOut, gotIv, res, ivn);
        end
    endtask

    // dutB: core_done pulsed in IDLE and in LOAD must not complete anything.
    task automatic test_stray_done;
        int nOut, nErr, errCyc;
        nOut = 0; nErr = 0; errCyc = -1;
        @(negedge hclk);
        core_doneB = 1'b1; core_doutB = {$urandom, $urandom};
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge hclk);
            core_doneB = 1'b0;
            #1;
            if (out_validB === 1'b1 || busyB === 1'b1) nOut++;
        end
        checks++;
        if (nOut != 0) begin
            errors++;
            $display("[TB] FAIL stray_done_idle: %0d cycles with out_valid/busy, expected 0", nOut);
        end
        nOut = 0;
        @(negedge hclk);
        startB = 1'b1; blkB = {$urandom, $urandom}; cbcB = 1'b0; encB = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge hclk);
            startB = 1'b0;
            core_doneB = (cyc == 1) ? 1'b1 : 1'b0;
            #1;
            if (out_validB === 1'b1) nOut++;
            if (errB === 1'b1) begin nErr++; errCyc = cyc; end
        end
        checks++;
        if (nOut != 0 || nErr != 1 || errCyc != TO_B + 1) begin
            errors++;
            $display("[TB] FAIL stray_done_load: out_valid=%0d err=%0d at cycle %0d, expected 0 1 at cycle %0d",
                     nOut, nErr, errCyc, TO_B + 1);
        end
    endtask

    initial begin
        hresetn = 1'b0;
        startA = 1'b0; cbcA = 1'b0; encA = 1'b1; blkA = '0; ivA = '0;
        core_doneA = 1'b0; core_doutA = '0;
        startB = 1'b0; cbcB = 1'b0; encB = 1'b1; blkB = '0; ivB = {$urandom, $urandom};
        core_doneB = 1'b0; core_doutB = '0;
        test_reset;
        test_cbc_encrypt;
`ifdef DES_CBC_DECRYPT_EN
        test_cbc_decrypt;
`endif
        test_ecb;
        test_random;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid;
        test_timeout;
        test_timeout_priority;
        test_stray_done;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_time_limit: bench still running at %0t, expected completion", $time);
        $fatal(1, "[TB] time limit reached");
    end

endmodule
